// File: rtl/bt_uart_core.sv
// bt_uart_core: byte UART with tx holding register and rx data register.
// Define BT_UART_PARITY_EN to add an even-parity bit and the parity_err output.
module bt_uart_core #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       wen,
  input  logic       oen,
  output logic [7:0] data_out,
  output logic       rxrdy,
  output logic       txrdy,
  input  logic       rx,
  output logic       tx,
  output logic       framing_err,
`ifdef BT_UART_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overflow
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} st_t;
`ifdef BT_UART_PARITY_EN
  localparam st_t AFTER_DATA = S_PARITY;
`else
  localparam st_t AFTER_DATA = S_STOP;
`endif
  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] MID = 16'(BAUD_DIV / 2 - 1);
  st_t tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, hold_q, hold_d, rx_sh_q, rx_sh_d, data_out_q, data_out_d;
  logic tx_par_q, tx_par_d, txrdy_q, txrdy_d, tx_q, tx_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q, rxrdy_q, rxrdy_d, fe_q, fe_d, ovf_q, ovf_d;
  logic pbad_q, pbad_d, perr_q, perr_d;
  logic tx_end, rx_end, load;
  always_comb begin
    tx_st_d = tx_st_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_par_d = tx_par_q;
    hold_d = hold_q;
    txrdy_d = txrdy_q;
    tx_end = tx_cnt_q == LAST;
    tx_cnt_d = (tx_st_q == S_IDLE || tx_end) ? 16'd0 : tx_cnt_q + 16'd1;
    if (!wen && txrdy_q) begin
      hold_d = data_in;
      txrdy_d = 1'b0;
    end
    case (tx_st_q)
      S_START:  tx_st_d = tx_end ? S_DATA : S_START;
      S_DATA: if (tx_end) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_st_d = (tx_bit_q == 3'd7) ? AFTER_DATA : S_DATA;
      end
      S_PARITY: tx_st_d = tx_end ? S_STOP : S_PARITY;
      S_STOP:   tx_st_d = tx_end ? S_IDLE : S_STOP;
      default:  tx_st_d = S_IDLE;
    endcase
    // Loading straight out of a finished stop bit keeps back-to-back frames gapless.
    load = !txrdy_q && (tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_end));
    if (load) begin
      tx_st_d = S_START;
      tx_sh_d = hold_q;
      tx_par_d = ^hold_q;
      tx_bit_d = 3'd0;
      txrdy_d = 1'b1;
    end
    tx_d = tx_st_d == S_START ? 1'b0 : tx_st_d == S_DATA ? tx_sh_d[0] :
           tx_st_d == S_PARITY ? tx_par_d : 1'b1;
  end
  always_comb begin
    rx_st_d = rx_st_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    data_out_d = data_out_q;
    rxrdy_d = oen ? rxrdy_q : 1'b0;
    ovf_d = (!oen && rxrdy_q) ? 1'b0 : ovf_q;
    fe_d = fe_q;
    pbad_d = pbad_q;
    perr_d = perr_q;
    rx_end = rx_cnt_q == ((rx_st_q == S_START) ? MID : LAST);
    rx_cnt_d = (rx_st_q == S_IDLE || rx_end) ? 16'd0 : rx_cnt_q + 16'd1;
    case (rx_st_q)
      S_IDLE:  rx_st_d = (rx_prev_q && !rx_s2_q) ? S_START : S_IDLE;
      S_START: if (rx_end) begin
        rx_st_d = rx_s2_q ? S_IDLE : S_DATA;
        rx_bit_d = 3'd0;
      end
      S_DATA: if (rx_end) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_st_d = (rx_bit_q == 3'd7) ? AFTER_DATA : S_DATA;
      end
      S_PARITY: if (rx_end) begin
        pbad_d = ^rx_sh_q ^ rx_s2_q;
        rx_st_d = S_STOP;
      end
      S_STOP: if (rx_end) begin
        rx_st_d = S_IDLE;
        // A byte arriving while the previous one is unread is dropped, not merged.
        if (rxrdy_q) ovf_d = 1'b1;
        else begin
          data_out_d = rx_sh_q;
          rxrdy_d = 1'b1;
          fe_d = !rx_s2_q;
          perr_d = pbad_q;
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_par_q <= 1'b0;
      hold_q <= '0;
      txrdy_q <= 1'b1;
      tx_q <= 1'b1;
      rx_st_q <= S_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      data_out_q <= '0;
      rxrdy_q <= 1'b0;
      fe_q <= 1'b0;
      ovf_q <= 1'b0;
      pbad_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_par_q <= tx_par_d;
      hold_q <= hold_d;
      txrdy_q <= txrdy_d;
      tx_q <= tx_d;
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      data_out_q <= data_out_d;
      rxrdy_q <= rxrdy_d;
      fe_q <= fe_d;
      ovf_q <= ovf_d;
      pbad_q <= pbad_d;
      perr_q <= perr_d;
    end
  end
  assign data_out = data_out_q;
  assign rxrdy = rxrdy_q;
  assign txrdy = txrdy_q;
  assign tx = tx_q;
  assign framing_err = fe_q;
  assign overflow = ovf_q;
`ifdef BT_UART_PARITY_EN
  assign parity_err = perr_q;
`else
  logic unused_parity;
  assign unused_parity = ^{pbad_q, perr_q, tx_par_q};
`endif
endmodule

// File: tb/tb_bt_uart_core.sv
// tb_bt_uart_core: directed vector bench for bt_uart_core at BAUD_DIV=8.
module tb_bt_uart_core;
  logic clk = 1'b0, rst = 1'b1, wen = 1'b1, oen = 1'b1, rx_drv = 1'b1, loop = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic rxrdy, txrdy, tx, framing_err, overflow, rx_w;
`ifdef BT_UART_PARITY_EN
  logic parity_err;
`endif
  int errs = 0, checks = 0;
  assign rx_w = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  bt_uart_core #(.BAUD_DIV(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wen(wen), .oen(oen),
    .data_out(data_out), .rxrdy(rxrdy), .txrdy(txrdy), .rx(rx_w), .tx(tx),
    .framing_err(framing_err),
`ifdef BT_UART_PARITY_EN
    .parity_err(parity_err),
`endif
    .overflow(overflow));
  typedef struct { logic [7:0] d; logic [9:0] frame; } tx_vec_t;
  typedef struct { logic [7:0] d; logic stop; logic glitch; logic rdy; logic [7:0] exp; logic fe; } rx_vec_t;
  tx_vec_t tv[4];
  rx_vec_t rv[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic sample_bits(input int n, input int first, output logic [19:0] b);
    b = '0;
    repeat (first) tick();
    b[0] = tx;
    for (int i = 1; i < n; i++) begin
      repeat (8) tick();
      b[i] = tx;
    end
  endtask
  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (8) tick();
    end
    rx_drv = 1'b1;
    repeat (4) tick();
  endtask
  task automatic count_tx_low(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!tx) lows++;
    end
  endtask
  task automatic wait_rxrdy(input int lim);
    int n = 0;
    while (!rxrdy && n < lim) begin
      tick();
      n++;
    end
    chk("rxrdy_wait", rxrdy, 1'b1);
  endtask
  initial begin
    logic [19:0] b;
    int lows;
    tv[0] = '{8'h55, 10'b1010101010};
    tv[1] = '{8'hA3, 10'b1101000110};
    tv[2] = '{8'h00, 10'b1000000000};
    tv[3] = '{8'hFF, 10'b1111111110};
    rv[0] = '{8'hA3, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0};
    rv[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
    rv[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0};
    rv[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0};
    rv[4] = '{8'h7E, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b1};
    rv[5] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0};
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_tx", tx, 1'b1);
    chk("rst_txrdy", txrdy, 1'b1);
    chk("rst_rxrdy", rxrdy, 1'b0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_framing_err", framing_err, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    tick();
    for (int v = 0; v < 4; v++) begin
      data_in = tv[v].d;
      wen = 1'b0;
      tick();
      wen = 1'b1;
      chk("tx_txrdy_low", txrdy, 1'b0);
      tick();
      chk("tx_txrdy_reload", txrdy, 1'b1);
      sample_bits(10, 4, b);
      chk("tx_frame", b[9:0], tv[v].frame);
      repeat (6) tick();
    end
    data_in = 8'h00;
    wen = 1'b0;
    tick();
    data_in = 8'h81;
    tick();
    wen = 1'b1;
    sample_bits(10, 4, b);
    chk("tx_ignored_wen_frame", b[9:0], 10'b1000000000);
    count_tx_low(100, lows);
    chk("tx_no_second_frame", lows, 0);
    data_in = 8'h0F;
    wen = 1'b0;
    tick();
    wen = 1'b1;
    tick();
    data_in = 8'hF0;
    wen = 1'b0;
    tick();
    wen = 1'b1;
    sample_bits(20, 3, b);
    chk("tx_back_to_back", b, {1'b1, 8'hF0, 1'b0, 1'b1, 8'h0F, 1'b0});
    repeat (6) tick();
    for (int v = 0; v < 6; v++) begin
      if (rv[v].glitch) begin
        rx_drv = 1'b0;
        repeat (3) tick();
        rx_drv = 1'b1;
        repeat (100) tick();
      end else send_rx(rv[v].d, rv[v].stop);
      chk("rx_rxrdy", rxrdy, rv[v].rdy);
      chk("rx_data_out", data_out, rv[v].exp);
      chk("rx_framing_err", framing_err, rv[v].fe);
      if (rv[v].rdy) begin
        oen = 1'b0;
        tick();
        oen = 1'b1;
        chk("rx_rxrdy_after_oen", rxrdy, 1'b0);
      end
    end
    oen = 1'b0;
    tick();
    oen = 1'b1;
    chk("oen_idle_ignored", {rxrdy, overflow, data_out}, {2'b00, 8'h5A});
    send_rx(8'h11, 1'b1);
    chk("ovf_first_clear", overflow, 1'b0);
    send_rx(8'h22, 1'b1);
    chk("ovf_data_out", data_out, 8'h11);
    chk("ovf_set", {rxrdy, overflow}, 2'b11);
    oen = 1'b0;
    tick();
    oen = 1'b1;
    chk("ovf_cleared", {rxrdy, overflow}, 2'b00);
    data_in = 8'hFF;
    wen = 1'b0;
    tick();
    wen = 1'b1;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_tx", {tx, txrdy}, 2'b11);
    rst = 1'b0;
    count_tx_low(100, lows);
    chk("rst_abandon", lows, 0);
    loop = 1'b1;
    repeat (4) tick();
    data_in = 8'h00;
    wen = 1'b0;
    tick();
    wen = 1'b1;
    for (int v = 0; v < 256; v++) begin
      wait_rxrdy(200);
      chk("loop_data", data_out, 32'(v));
      if (v < 255) begin
        data_in = 8'(v + 1);
        wen = 1'b0;
      end
      oen = 1'b0;
      tick();
      wen = 1'b1;
      oen = 1'b1;
      chk("loop_ops", {rxrdy, txrdy}, (v < 255) ? 2'b00 : 2'b01);
    end
    chk("loop_overflow", overflow, 1'b0);
    loop = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
